keypad_scan_debounce: RTL and testbench

- Upstream input stage of the calculator datapath.
- Drives the rows of the 4x4 matrix keypad and senses its columns.
- Debounces both press and release, then emits a single 4-bit key code with a one-cycle valid strobe to the main calculator FSM.
- Runs from the low-frequency internal oscillator clock; one key is registered per physical press.

---
 rtl/keypad_scan_debounce.sv | 174 +++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: drives rows one-hot low, senses columns, debounces
// press and release, and emits one key code strobe per physical press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 10,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int         TW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          r_state;
  logic [3:0]      r_sync1;
  logic [3:0]      r_colS;
  logic [TW-1:0]   r_tickCnt;
  logic [1:0]      r_row;
  logic [1:0]      r_col;
  logic [3:0]      r_dbCnt;
  logic [3:0]      r_rowOut;
  logic [3:0]      r_keyCode;
  logic            r_keyValid;
  logic            r_keyHeld;

  logic            w_tick;
  logic [3:0]      w_low;
  logic            w_oneLow;
  logic [1:0]      w_colIdx;
  logic            w_allHigh;

  function automatic logic [3:0] rowDrive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  function automatic logic [3:0] keyMap(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: keyMap = 4'h1;
      4'b00_01: keyMap = 4'h2;
      4'b00_10: keyMap = 4'h3;
      4'b00_11: keyMap = 4'hA;
      4'b01_00: keyMap = 4'h4;
      4'b01_01: keyMap = 4'h5;
      4'b01_10: keyMap = 4'h6;
      4'b01_11: keyMap = 4'hB;
      4'b10_00: keyMap = 4'h7;
      4'b10_01: keyMap = 4'h8;
      4'b10_10: keyMap = 4'h9;
      4'b10_11: keyMap = 4'hC;
      4'b11_00: keyMap = 4'hE;
      4'b11_01: keyMap = 4'h0;
      4'b11_10: keyMap = 4'hF;
      default:  keyMap = 4'hD;
    endcase
  endfunction

  // Columns idle high, so the synchroniser resets to "no key" rather than a phantom press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 4'hF;
      r_colS  <= 4'hF;
    end else begin
      r_sync1 <= col_in;
      r_colS  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + TW'(1);
    end
  end

  assign w_tick    = (r_tickCnt == TW'(SCAN_DIV - 1));
  assign w_low     = ~r_colS;
  assign w_oneLow  = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);
  assign w_allHigh = (r_colS == 4'hF);

  always_comb begin
    w_colIdx = 2'd0;
    case (w_low)
      4'b0010: w_colIdx = 2'd1;
      4'b0100: w_colIdx = 2'd2;
      4'b1000: w_colIdx = 2'd3;
      default: w_colIdx = 2'd0;
    endcase
  end

  // The row register doubles as the latched row of the candidate key, so
  // row_out simply stays put in every state except a scan advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= SCAN;
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_dbCnt    <= 4'd0;
      r_rowOut   <= 4'b1110;
      r_keyCode  <= 4'h0;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
    end else begin
      r_keyValid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_oneLow) begin
              r_col   <= w_colIdx;
              r_dbCnt <= 4'd0;
              r_state <= DEBOUNCE;
            end else begin
              r_row    <= r_row + 2'd1;
              r_rowOut <= rowDrive(r_row + 2'd1);
            end
          end
          DEBOUNCE: begin
            if (w_oneLow && (w_colIdx == r_col)) begin
              if (r_dbCnt + 4'd1 == DB_LIM) begin
                r_keyCode  <= keyMap(r_row, r_col);
                r_keyValid <= 1'b1;
                r_keyHeld  <= 1'b1;
                r_state    <= PRESSED;
              end else if (r_dbCnt != 4'hF) begin
                r_dbCnt <= r_dbCnt + 4'd1;
              end
            end else begin
              r_dbCnt  <= 4'd0;
              r_row    <= r_row + 2'd1;
              r_rowOut <= rowDrive(r_row + 2'd1);
              r_state  <= SCAN;
            end
          end
          PRESSED: begin
            if (w_allHigh) begin
              r_dbCnt <= 4'd0;
              r_state <= RELEASE;
            end
          end
          default: begin
            if (w_allHigh) begin
              if (r_dbCnt + 4'd1 == DB_LIM) begin
                r_dbCnt   <= 4'd0;
                r_keyHeld <= 1'b0;
                r_row     <= r_row + 2'd1;
                r_rowOut  <= rowDrive(r_row + 2'd1);
                r_state   <= SCAN;
              end else if (r_dbCnt != 4'hF) begin
                r_dbCnt <= r_dbCnt + 4'd1;
              end
            end else begin
              r_state <= PRESSED;
            end
          end
        endcase
      end
    end
  end

  assign row_out   = r_rowOut;
  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;
  assign key_held  = r_keyHeld;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce: a keypad matrix model driven by a
// key mask, with expected key codes queued on press and popped on each strobe.
module tb_keypad_scan_debounce;

  logic        clk;
  logic        resetn;
  logic [3:0]  colIn;
  logic [3:0]  rowOut;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyHeld;

  logic [15:0] keyMask;
  logic [3:0]  expQ[$];
  int          checkCount;
  int          errorCount;
  int          strobeCount;
  int          pushCount;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .col_in   (colIn),
    .row_out  (rowOut),
    .key_code (keyCode),
    .key_valid(keyValid),
    .key_held (keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its column low only while its row is driven low.
  always_comb begin
    colIn = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyMask[r*4+c] && !rowOut[r]) colIn[c] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask);
    keyMask = mask;
  endtask

  task automatic pushExpected(input logic [3:0] code);
    expQ.push_back(code);
    pushCount++;
  endtask

  task automatic waitStrobe(input string tag, input int limit);
    int n = 0;
    while (!keyValid && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, keyValid, 1'b1);
    checkOutput({tag, "_held"}, keyHeld, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_width"}, keyValid, 1'b0);
  endtask

  task automatic waitHeldLow(input int limit, output int n);
    n = 0;
    while (keyHeld && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitRow(input string tag, input logic [3:0] target, input int limit);
    int n = 0;
    while (rowOut !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, rowOut, target);
  endtask

  // Scoreboard side: every strobe must match the oldest queued key code.
  always @(negedge clk) begin
    if (resetn && keyValid) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        checkOutput("key_code", keyCode, expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rowSeq [4];
    logic [3:0] seen;
    int         n;
    int         drops;

    rowSeq      = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    checkCount  = 0;
    errorCount  = 0;
    strobeCount = 0;
    pushCount   = 0;
    applyStimulus(16'h0000);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_row_out", rowOut, 4'b1110);
    checkOutput("rst_key_code", keyCode, 4'h0);
    checkOutput("rst_key_valid", keyValid, 1'b0);
    checkOutput("rst_key_held", keyHeld, 1'b0);

    // Idle scan: each row held four clocks, starting with row 0.
    resetn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_row_%0d", k), rowOut, rowSeq[(k / 4) % 4]);
    end

    // Key "6" held steady then released; scan resumes on the next row.
    pushExpected(4'h6);
    applyStimulus(16'h0001 << 6);
    waitStrobe("strobe_6", 100);
    repeat (10) @(negedge clk);
    applyStimulus(16'h0000);
    waitHeldLow(60, n);
    checkOutput("held_fall_6", keyHeld, 1'b0);
    checkOutput("held_time_6", (n >= 10 && n <= 20), 1'b1);
    checkOutput("resume_row2", rowOut, 4'b1011);
    checkOutput("code_hold_6", keyCode, 4'h6);

    // Key "0" bounces before settling; only the settled press may strobe.
    for (int b = 0; b < 5; b++) begin
      applyStimulus(16'h0001 << 13);
      repeat (6) @(negedge clk);
      applyStimulus(16'h0000);
      repeat (6) @(negedge clk);
    end
    pushExpected(4'h0);
    applyStimulus(16'h0001 << 13);
    waitStrobe("strobe_0", 150);
    repeat (5) @(negedge clk);
    applyStimulus(16'h0000);
    waitHeldLow(60, n);
    checkOutput("held_fall_0", keyHeld, 1'b0);

    // Key "A" with a one-tick release glitch while pressed.
    pushExpected(4'hA);
    applyStimulus(16'h0001 << 3);
    waitStrobe("strobe_A", 100);
    repeat (20) @(negedge clk);
    applyStimulus(16'h0000);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0001 << 3);
    drops = 0;
    repeat (40) begin
      @(negedge clk);
      if (!keyHeld) drops++;
    end
    checkOutput("glitch_held_drops", drops, 0);
    applyStimulus(16'h0000);
    waitHeldLow(60, n);
    checkOutput("held_fall_A", keyHeld, 1'b0);

    // Two columns low on row 0: ignored, scan keeps cycling.
    applyStimulus(16'h0003);
    seen = 4'h0;
    repeat (64) begin
      @(negedge clk);
      seen = seen | ~rowOut;
    end
    checkOutput("multi_scan_rows", seen, 4'hF);
    checkOutput("multi_held", keyHeld, 1'b0);
    applyStimulus(16'h0000);

    // Reset in the middle of debouncing "9" discards the press.
    waitRow("wait_row1", 4'b1101, 64);
    applyStimulus(16'h0001 << 10);
    waitRow("wait_row2", 4'b1011, 64);
    repeat (8) @(negedge clk);
    checkOutput("debounce_row_hold", rowOut, 4'b1011);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_row_out", rowOut, 4'b1110);
    checkOutput("mid_rst_key_code", keyCode, 4'h0);
    checkOutput("mid_rst_key_valid", keyValid, 1'b0);
    checkOutput("mid_rst_key_held", keyHeld, 1'b0);
    applyStimulus(16'h0000);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("post_rst_code", keyCode, 4'h0);

    pushExpected(4'h9);
    applyStimulus(16'h0001 << 10);
    waitStrobe("strobe_9", 100);
    applyStimulus(16'h0000);
    waitHeldLow(60, n);
    checkOutput("held_fall_9", keyHeld, 1'b0);

    repeat (10) @(negedge clk);
    checkOutput("sb_empty", expQ.size(), 0);
    checkOutput("strobe_total", strobeCount, pushCount);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
